// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Instruction-fetch controller. Owns the fetch PC, issues requests to
// instruction memory, and sequences sequential advance, hazard stalls,
// branch/jump redirects and traps.
//
// Parameters
//   RESET_PC        PC loaded on reset
//   TRAP_VEC        PC target taken on a trap
//
// Ports
//   clk             single clock, rising-edge state updates
//   rst             asynchronous, active-low reset
//   stall           hazard-unit hold request
//   redirect_valid  taken branch/jump from EX
//   redirect_target branch/jump destination
//   trap_valid      trap request, overrides redirect
//   imem_req        instruction-memory request, held until imem_ack
//   imem_addr       fetch address (always equal to pc)
//   imem_ack        one-cycle completion of the current request
//   pc              registered current fetch PC
//   pc_next         value pc takes on the next edge
//   if_valid        instruction at pc is valid for IF/ID
//   flush           one-cycle pulse killing IF/ID on redirect or trap
//   misalign_err    sticky misaligned-redirect flag
//
// Configuration macro
//   FETCH_CTRL_MISALIGN_CHECK_EN  when defined, a redirect whose target has
//   nonzero low bits is handled as a trap and sets misalign_err until reset.
//   When undefined, the low two target bits are forced to zero and
//   misalign_err is tied low.

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        if_valid,
    output logic        flush,
    output logic        misalign_err
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] pending;
    logic [31:0] pending_next;
    logic [31:0] pc_inc;

    logic        take_trap;
    logic        take_redir;
    logic        ctrl;
    logic [31:0] redir_addr;
    logic [31:0] target;

`ifdef FETCH_CTRL_MISALIGN_CHECK_EN
    logic misaligned;
    logic misalign_q;
    logic misalign_set;

    // A misaligned redirect is promoted to a trap so the core vectors to
    // TRAP_VEC instead of fetching from an illegal address.
    assign misaligned = (redirect_target[1:0] != 2'b00);
    assign take_trap  = trap_valid || (redirect_valid && misaligned);
    assign redir_addr = redirect_target;

    // Only flag the error when the misaligned redirect is the event being
    // acted on; a simultaneous real trap already wins.
    assign misalign_set = (state != BOOT) && redirect_valid && misaligned && !trap_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else if (misalign_set) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_err = misalign_q;
`else
    logic unused_target_low;

    assign take_trap         = trap_valid;
    assign redir_addr        = {redirect_target[31:2], 2'b00};
    assign unused_target_low = ^redirect_target[1:0];
    assign misalign_err      = 1'b0;
`endif

    assign take_redir = redirect_valid && !take_trap;
    assign ctrl       = take_trap || take_redir;
    assign target     = take_trap ? TRAP_VEC : redir_addr;

    // 32-bit add wraps naturally from FFFF_FFFC to 0000_0000.
    assign pc_inc    = pc + 32'd4;
    assign imem_addr = pc;

    // Next-state, next-pc and output decode. A control event (trap or
    // redirect) always flushes IF/ID. In FETCH it retargets immediately if
    // the in-flight request completes this cycle, otherwise the request is
    // allowed to finish in DRAIN with the target parked in 'pending' so the
    // memory never sees an aborted request.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        pending_next = pending;
        imem_req     = 1'b0;
        if_valid     = 1'b0;
        flush        = 1'b0;

        case (state)
            BOOT: begin
                state_next = FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (ctrl) begin
                    flush = 1'b1;
                    if (imem_ack) begin
                        pc_next = target;
                    end else begin
                        pending_next = target;
                        state_next   = DRAIN;
                    end
                end else if (imem_ack) begin
                    if_valid = 1'b1;
                    if (stall) begin
                        state_next = HOLD;
                    end else begin
                        pc_next = pc_inc;
                    end
                end
            end

            HOLD: begin
                if (ctrl) begin
                    flush      = 1'b1;
                    pc_next    = target;
                    state_next = FETCH;
                end else begin
                    if_valid = 1'b1;
                    if (!stall) begin
                        pc_next    = pc_inc;
                        state_next = FETCH;
                    end
                end
            end

            DRAIN: begin
                // The response to the old pc is discarded; stall is ignored
                // because the request must stay asserted until acked.
                imem_req = 1'b1;
                if (ctrl) begin
                    flush = 1'b1;
                    if (imem_ack) begin
                        pc_next    = target;
                        state_next = FETCH;
                    end else begin
                        pending_next = target;
                    end
                end else if (imem_ack) begin
                    pc_next    = pending;
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            pending <= 32'h0000_0000;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// Directed self-checking bench for fetch_ctrl. Inputs change on the falling
// edge; outputs are sampled 2 time units later, well clear of the rising edge.
// Expected values for the misaligned-redirect case follow the
// FETCH_CTRL_MISALIGN_CHECK_EN macro.

module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        if_valid;
    logic        flush;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .TRAP_VEC (32'h0000_0100)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .pc              (pc),
        .pc_next         (pc_next),
        .if_valid        (if_valid),
        .flush           (flush),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs at the falling edge, then settle.
    task automatic drive(input logic st, input logic rv, input logic [31:0] rt,
                         input logic tv, input logic ak);
        @(negedge clk);
        stall           = st;
        redirect_valid  = rv;
        redirect_target = rt;
        trap_valid      = tv;
        imem_ack        = ak;
        #2;
    endtask

    task automatic test_reset();
        drive(0, 0, 32'h0, 0, 1);
        total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL rst_pc: got %h want %h", pc, 32'h0); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_req: got %b want 0", imem_req); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_ifv: got %b want 0", if_valid); end
        total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL rst_flush: got %b want 0", flush); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_mis: got %b want 0", misalign_err); end
        rst = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL boot_req: got %b want 0", imem_req); end
        total++; if (pc_next !== 32'h0) begin bad++; $display("[TB] FAIL boot_pcn: got %h want %h", pc_next, 32'h0); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 32'h0, 0, 1);
            total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL seq_req[%0d]: got %b want 1", i, imem_req); end
            total++; if (imem_addr !== 32'(i * 4)) begin bad++; $display("[TB] FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, 32'(i * 4)); end
            total++; if (if_valid !== 1'b1) begin bad++; $display("[TB] FAIL seq_ifv[%0d]: got %b want 1", i, if_valid); end
            total++; if (pc_next !== 32'(i * 4 + 4)) begin bad++; $display("[TB] FAIL seq_pcn[%0d]: got %h want %h", i, pc_next, 32'(i * 4 + 4)); end
        end
    endtask

    task automatic test_stall();
        drive(1, 0, 32'h0, 0, 1);
        total++; if (imem_addr !== 32'h8) begin bad++; $display("[TB] FAIL stall_addr: got %h want %h", imem_addr, 32'h8); end
        total++; if (if_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_ifv0: got %b want 1", if_valid); end
        total++; if (pc_next !== 32'h8) begin bad++; $display("[TB] FAIL stall_pcn0: got %h want %h", pc_next, 32'h8); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h0, 0, 0);
            total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL hold_req[%0d]: got %b want 0", i, imem_req); end
            total++; if (if_valid !== 1'b1) begin bad++; $display("[TB] FAIL hold_ifv[%0d]: got %b want 1", i, if_valid); end
            total++; if (pc !== 32'h8) begin bad++; $display("[TB] FAIL hold_pc[%0d]: got %h want %h", i, pc, 32'h8); end
        end
        drive(0, 0, 32'h0, 0, 0);
        total++; if (pc_next !== 32'hC) begin bad++; $display("[TB] FAIL unstall_pcn: got %h want %h", pc_next, 32'hC); end
        drive(1, 0, 32'h0, 0, 0);
        total++; if (pc !== 32'hC) begin bad++; $display("[TB] FAIL unstall_pc: got %h want %h", pc, 32'hC); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL fetch_stall_req: got %b want 1", imem_req); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL fetch_stall_ifv: got %b want 0", if_valid); end
        drive(0, 0, 32'h0, 0, 1);
        total++; if (pc_next !== 32'h10) begin bad++; $display("[TB] FAIL after_stall_pcn: got %h want %h", pc_next, 32'h10); end
    endtask

    task automatic test_redirect_drain();
        drive(0, 1, 32'h200, 0, 0);
        total++; if (pc !== 32'h10) begin bad++; $display("[TB] FAIL rd_pc: got %h want %h", pc, 32'h10); end
        total++; if (flush !== 1'b1) begin bad++; $display("[TB] FAIL rd_flush: got %b want 1", flush); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL rd_ifv: got %b want 0", if_valid); end
        total++; if (pc_next !== 32'h10) begin bad++; $display("[TB] FAIL rd_pcn: got %h want %h", pc_next, 32'h10); end
        drive(0, 0, 32'h0, 0, 0);
        total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL drain_req: got %b want 1", imem_req); end
        total++; if (imem_addr !== 32'h10) begin bad++; $display("[TB] FAIL drain_addr: got %h want %h", imem_addr, 32'h10); end
        total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL drain_flush: got %b want 0", flush); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_ifv: got %b want 0", if_valid); end
        drive(0, 0, 32'h0, 0, 1);
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_ack_ifv: got %b want 0", if_valid); end
        total++; if (pc_next !== 32'h200) begin bad++; $display("[TB] FAIL drain_ack_pcn: got %h want %h", pc_next, 32'h200); end
        drive(0, 0, 32'h0, 0, 0);
        total++; if (imem_addr !== 32'h200) begin bad++; $display("[TB] FAIL rd_new_addr: got %h want %h", imem_addr, 32'h200); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL rd_new_req: got %b want 1", imem_req); end
    endtask

    task automatic test_latest_wins();
        drive(0, 1, 32'h280, 0, 0);
        total++; if (flush !== 1'b1) begin bad++; $display("[TB] FAIL lw_flush0: got %b want 1", flush); end
        drive(0, 1, 32'h240, 0, 0);
        total++; if (flush !== 1'b1) begin bad++; $display("[TB] FAIL lw_flush1: got %b want 1", flush); end
        drive(1, 0, 32'h0, 0, 1);
        total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL lw_flush2: got %b want 0", flush); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL lw_ifv: got %b want 0", if_valid); end
        total++; if (pc_next !== 32'h240) begin bad++; $display("[TB] FAIL lw_pcn: got %h want %h", pc_next, 32'h240); end
        drive(0, 0, 32'h0, 0, 0);
        total++; if (pc !== 32'h240) begin bad++; $display("[TB] FAIL lw_pc: got %h want %h", pc, 32'h240); end
    endtask

    task automatic test_trap_priority();
        drive(0, 1, 32'h300, 1, 1);
        total++; if (flush !== 1'b1) begin bad++; $display("[TB] FAIL trap_flush: got %b want 1", flush); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL trap_ifv: got %b want 0", if_valid); end
        total++; if (pc_next !== 32'h100) begin bad++; $display("[TB] FAIL trap_pcn: got %h want %h", pc_next, 32'h100); end
        drive(0, 0, 32'h0, 0, 0);
        total++; if (pc !== 32'h100) begin bad++; $display("[TB] FAIL trap_pc: got %h want %h", pc, 32'h100); end
    endtask

    task automatic test_hold_redirect();
        drive(1, 0, 32'h0, 0, 1);
        total++; if (if_valid !== 1'b1) begin bad++; $display("[TB] FAIL hr_ifv0: got %b want 1", if_valid); end
        drive(1, 1, 32'h400, 0, 0);
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL hr_ifv1: got %b want 0", if_valid); end
        total++; if (flush !== 1'b1) begin bad++; $display("[TB] FAIL hr_flush: got %b want 1", flush); end
        total++; if (pc_next !== 32'h400) begin bad++; $display("[TB] FAIL hr_pcn: got %h want %h", pc_next, 32'h400); end
        drive(0, 0, 32'h0, 0, 0);
        total++; if (pc !== 32'h400) begin bad++; $display("[TB] FAIL hr_pc: got %h want %h", pc, 32'h400); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL hr_req: got %b want 1", imem_req); end
    endtask

    task automatic test_wrap();
        drive(0, 1, 32'hFFFF_FFFC, 0, 1);
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL wrap_ifv0: got %b want 0", if_valid); end
        total++; if (pc_next !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_pcn0: got %h want %h", pc_next, 32'hFFFF_FFFC); end
        drive(0, 0, 32'h0, 0, 1);
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_addr: got %h want %h", imem_addr, 32'hFFFF_FFFC); end
        total++; if (if_valid !== 1'b1) begin bad++; $display("[TB] FAIL wrap_ifv1: got %b want 1", if_valid); end
        total++; if (pc_next !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pcn1: got %h want %h", pc_next, 32'h0); end
        drive(0, 0, 32'h0, 0, 0);
        total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc: got %h want %h", pc, 32'h0); end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc;
        logic        exp_err;
`ifdef FETCH_CTRL_MISALIGN_CHECK_EN
        exp_pc  = 32'h100;
        exp_err = 1'b1;
`else
        exp_pc  = 32'h200;
        exp_err = 1'b0;
`endif
        drive(0, 1, 32'h202, 0, 1);
        total++; if (pc_next !== exp_pc) begin bad++; $display("[TB] FAIL mis_pcn: got %h want %h", pc_next, exp_pc); end
        total++; if (flush !== 1'b1) begin bad++; $display("[TB] FAIL mis_flush: got %b want 1", flush); end
        drive(0, 0, 32'h0, 0, 0);
        total++; if (pc !== exp_pc) begin bad++; $display("[TB] FAIL mis_pc: got %h want %h", pc, exp_pc); end
        total++; if (misalign_err !== exp_err) begin bad++; $display("[TB] FAIL mis_err0: got %b want %b", misalign_err, exp_err); end
        drive(0, 0, 32'h0, 0, 1);
        total++; if (misalign_err !== exp_err) begin bad++; $display("[TB] FAIL mis_err1: got %b want %b", misalign_err, exp_err); end
        total++; if (pc_next !== exp_pc + 32'd4) begin bad++; $display("[TB] FAIL mis_pcn1: got %h want %h", pc_next, exp_pc + 32'd4); end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 32'h0, 0, 0);
        total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL rm_req0: got %b want 1", imem_req); end
        rst = 1'b0;
        #1;
        total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL rm_pc: got %h want %h", pc, 32'h0); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL rm_req1: got %b want 0", imem_req); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL rm_mis: got %b want 0", misalign_err); end
        drive(0, 0, 32'h0, 0, 1);
        total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL rm_pc_ack: got %h want %h", pc, 32'h0); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL rm_ifv: got %b want 0", if_valid); end
        rst = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL rm_boot_req: got %b want 0", imem_req); end
        total++; if (pc_next !== 32'h0) begin bad++; $display("[TB] FAIL rm_boot_pcn: got %h want %h", pc_next, 32'h0); end
        drive(0, 0, 32'h0, 0, 1);
        total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL rm_fetch_req: got %b want 1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL rm_fetch_addr: got %h want %h", imem_addr, 32'h0); end
        total++; if (if_valid !== 1'b1) begin bad++; $display("[TB] FAIL rm_fetch_ifv: got %b want 1", if_valid); end
    endtask

    initial begin
        rst             = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        trap_valid      = 1'b0;
        imem_ack        = 1'b0;

        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drain();
        test_latest_wins();
        test_trap_priority();
        test_hold_redirect();
        test_wrap();
        test_misalign();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
